// File: rtl/player_step_ctrl_pkg.sv
// Shared game parameters for the player step controller: map geometry,
// start position, tile id ranges and move direction encoding.
package player_step_ctrl_pkg;

  localparam int MAP_WIDTH  = 13;
  localparam int MAP_HEIGHT = 13;
  localparam int START_X    = 6;
  localparam int START_Y    = 11;
  localparam int TILE_FLOOR = 0;
  localparam int ITEM_LO    = 16;
  localparam int ITEM_HI    = 31;

  // Bit positions inside the move_req vector.
  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Fixed priority up > down > left > right; only meaningful when req != 0.
  function automatic dir_e pick_dir(input logic [3:0] req);
    if (req[BIT_UP])        return DIR_UP;
    else if (req[BIT_DOWN]) return DIR_DOWN;
    else if (req[BIT_LEFT]) return DIR_LEFT;
    else                    return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/player_step_ctrl_step_target.sv
// Combinational target calculator: one tile step from (x,y) in a direction,
// with the map-edge check and the linear tile address of the target.
module step_target #(
  parameter int MAP_WIDTH  = player_step_ctrl_pkg::MAP_WIDTH,
  parameter int MAP_HEIGHT = player_step_ctrl_pkg::MAP_HEIGHT
) (
  input  player_step_ctrl_pkg::dir_e dir_i,
  input  logic [3:0]                 x_i,
  input  logic [3:0]                 y_i,
  output logic [3:0]                 tx_o,
  output logic [3:0]                 ty_o,
  output logic                       oob_o,
  output logic [18:0]                addr_o
);
  import player_step_ctrl_pkg::*;

  localparam logic [3:0]  X_MAX = 4'(MAP_WIDTH - 1);
  localparam logic [3:0]  Y_MAX = 4'(MAP_HEIGHT - 1);
  localparam logic [18:0] ROW_W = 19'(MAP_WIDTH);

  // Step one tile; the wrapped coordinate on an edge is never used because oob_o is set.
  always_comb begin
    tx_o  = x_i;
    ty_o  = y_i;
    oob_o = 1'b0;
    case (dir_i)
      DIR_UP: begin
        oob_o = (y_i == 4'd0);
        ty_o  = y_i - 4'd1;
      end
      DIR_DOWN: begin
        oob_o = (y_i == Y_MAX);
        ty_o  = y_i + 4'd1;
      end
      DIR_LEFT: begin
        oob_o = (x_i == 4'd0);
        tx_o  = x_i - 4'd1;
      end
      default: begin
        oob_o = (x_i == X_MAX);
        tx_o  = x_i + 4'd1;
      end
    endcase
    addr_o = ({15'd0, ty_o} * ROW_W) + {15'd0, tx_o};
  end

endmodule

// File: rtl/player_step_ctrl.sv
// Player step controller: takes a latched direction request, checks the map
// edge, reads the target tile through the map bRAM port B, moves onto floor,
// picks up items (writing floor back) and acknowledges the request.
module player_step_ctrl #(
  parameter int MAP_WIDTH  = player_step_ctrl_pkg::MAP_WIDTH,
  parameter int MAP_HEIGHT = player_step_ctrl_pkg::MAP_HEIGHT,
  parameter int START_X    = player_step_ctrl_pkg::START_X,
  parameter int START_Y    = player_step_ctrl_pkg::START_Y,
  parameter int RD_LAT     = 1,
  parameter int TILE_FLOOR = player_step_ctrl_pkg::TILE_FLOOR,
  parameter int ITEM_LO    = player_step_ctrl_pkg::ITEM_LO,
  parameter int ITEM_HI    = player_step_ctrl_pkg::ITEM_HI
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  move_req,
  output logic        move_ack,
  output logic [18:0] map_addr,
  input  logic [15:0] map_rdata,
  output logic        map_we,
  output logic [15:0] map_wdata,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic        busy,
  output logic        item_got,
  output logic [15:0] item_id,
  output logic [15:0] step_cnt
);
  import player_step_ctrl_pkg::*;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;

  localparam logic [1:0]  LAT_INIT   = 2'(RD_LAT - 1);
  localparam logic [3:0]  START_XV   = 4'(START_X);
  localparam logic [3:0]  START_YV   = 4'(START_Y);
  localparam logic [15:0] FLOOR_ID   = 16'(TILE_FLOOR);
  localparam logic [15:0] ITEM_LO_ID = 16'(ITEM_LO);
  localparam logic [15:0] ITEM_HI_ID = 16'(ITEM_HI);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [1:0]  lat_q;
  logic [3:0]  x_q, y_q, tx_q, ty_q;
  logic        oob_q;
  logic [18:0] taddr_q, addr_q;
  logic        we_q, ack_q, got_q, busy_q;
  logic [15:0] wdata_q, item_q, step_q;

  dir_e        req_dir;
  logic [3:0]  nx_x, nx_y;
  logic        nx_oob;
  logic [18:0] nx_addr;
  logic        is_floor, is_item;

  assign req_dir  = pick_dir(move_req);
  assign is_floor = (map_rdata == FLOOR_ID);
  assign is_item  = (map_rdata >= ITEM_LO_ID) && (map_rdata <= ITEM_HI_ID);

  step_target #(
    .MAP_WIDTH  (MAP_WIDTH),
    .MAP_HEIGHT (MAP_HEIGHT)
  ) u_step_target (
    .dir_i  (req_dir),
    .x_i    (x_q),
    .y_i    (y_q),
    .tx_o   (nx_x),
    .ty_o   (nx_y),
    .oob_o  (nx_oob),
    .addr_o (nx_addr)
  );

  // Next-state decode of the move handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (move_req != 4'd0) state_d = S_CHECK;
      S_CHECK:  state_d = oob_q ? S_ACK : S_READ;
      S_READ:   if (lat_q == 2'd0) state_d = S_DECIDE;
      S_DECIDE: state_d = (!is_floor && is_item) ? S_WRITE : S_ACK;
      S_WRITE:  state_d = S_ACK;
      S_ACK:    state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register and bRAM read-latency down-counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      lat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CHECK)
        lat_q <= LAT_INIT;
      else if (state_q == S_READ && lat_q != 2'd0)
        lat_q <= lat_q - 2'd1;
    end
  end

  // Registered outputs: target latch, map port B drive, position, pickup and counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_q    <= START_XV;
      ty_q    <= START_YV;
      oob_q   <= 1'b0;
      taddr_q <= 19'd0;
      addr_q  <= 19'd0;
      we_q    <= 1'b0;
      wdata_q <= 16'd0;
      ack_q   <= 1'b0;
      got_q   <= 1'b0;
      busy_q  <= 1'b0;
      item_q  <= 16'd0;
      step_q  <= 16'd0;
      x_q     <= START_XV;
      y_q     <= START_YV;
    end else begin
      ack_q  <= (state_q == S_ACK);
      busy_q <= (state_d != S_IDLE);
      we_q   <= 1'b0;
      got_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (move_req != 4'd0) begin
            tx_q    <= nx_x;
            ty_q    <= nx_y;
            oob_q   <= nx_oob;
            taddr_q <= nx_addr;
          end
        end
        S_CHECK: begin
          if (!oob_q) addr_q <= taddr_q;
        end
        S_DECIDE: begin
          if (is_floor) begin
            x_q    <= tx_q;
            y_q    <= ty_q;
            step_q <= sat_inc16(step_q);
          end else if (is_item) begin
            item_q  <= map_rdata;
            we_q    <= 1'b1;
            wdata_q <= FLOOR_ID;
            got_q   <= 1'b1;
          end
        end
        S_WRITE: begin
          x_q    <= tx_q;
          y_q    <= ty_q;
          step_q <= sat_inc16(step_q);
        end
        default: ;
      endcase
    end
  end

  assign move_ack  = ack_q;
  assign map_addr  = addr_q;
  assign map_we    = we_q;
  assign map_wdata = wdata_q;
  assign player_x  = x_q;
  assign player_y  = y_q;
  assign busy      = busy_q;
  assign item_got  = got_q;
  assign item_id   = item_q;
  assign step_cnt  = step_q;

endmodule

// File: tb/tb_player_step_ctrl.sv
// Self-checking bench for player_step_ctrl: a table of moves with hand-derived
// expectations queued on a scoreboard and popped on each move_ack, followed by
// hand-written reset and map-edge sequences.
module tb_player_step_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  move_req;
  logic        move_ack;
  logic [18:0] map_addr;
  logic [15:0] map_rdata;
  logic        map_we;
  logic [15:0] map_wdata;
  logic [3:0]  player_x, player_y;
  logic        busy, item_got;
  logic [15:0] item_id, step_cnt;

  always #5 clk = ~clk;

  player_step_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .move_req  (move_req),
    .move_ack  (move_ack),
    .map_addr  (map_addr),
    .map_rdata (map_rdata),
    .map_we    (map_we),
    .map_wdata (map_wdata),
    .player_x  (player_x),
    .player_y  (player_y),
    .busy      (busy),
    .item_got  (item_got),
    .item_id   (item_id),
    .step_cnt  (step_cnt)
  );

  // Map bRAM model, one-cycle read latency; contents set by the stimulus.
  logic [15:0] mem [0:255];
  always @(posedge clk) map_rdata <= mem[map_addr[7:0]];

  typedef struct {
    logic [3:0]  req;
    bit          oob;
    logic [18:0] addr;
    logic [15:0] tile;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] steps;
    int          lat;
    bit          we;
    logic [15:0] item;
  } vec_t;

  vec_t vecs [12];
  vec_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic [3:0] req, input bit oob, input int addr,
                              input int tile, input int x, input int y, input int steps,
                              input int lat, input bit we, input int item);
    vec_t v;
    v.req = req; v.oob = oob; v.addr = 19'(addr); v.tile = 16'(tile);
    v.x = 4'(x); v.y = 4'(y); v.steps = 16'(steps); v.lat = lat;
    v.we = we; v.item = 16'(item);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, follow it to move_ack, then pop and compare the scoreboard.
  task automatic run_move(input vec_t v);
    vec_t e;
    int   lat, wes, gots;
    bit   seen;
    if (!v.oob) mem[v.addr[7:0]] = v.tile;
    sb.push_back(v);
    move_req = v.req;
    tick();
    check("busy_after_sample", busy, 1);
    lat = 0; wes = 0; gots = 0; seen = 0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (map_we || item_got) begin
        check("got_we_align", item_got, map_we);
        if (map_we) begin
          wes++;
          check("we_addr", map_addr, v.addr);
          check("we_data", map_wdata, 0);
        end
        if (item_got) gots++;
      end
      if (move_ack) seen = 1;
    end
    check("ack_seen", seen, 1);
    e = sb.pop_front();
    check("ack_latency", lat, e.lat);
    check("player_x", player_x, e.x);
    check("player_y", player_y, e.y);
    check("step_cnt", step_cnt, e.steps);
    check("item_id", item_id, e.item);
    check("map_addr", map_addr, e.addr);
    check("we_pulses", wes, e.we ? 1 : 0);
    check("got_pulses", gots, e.we ? 1 : 0);
    // Upstream clears on the edge that sees the ack, so the request stays up through GAP.
    tick();
    move_req = 4'd0;
    check("ack_single", move_ack, 0);
    tick();
    check("idle_after_gap", busy, 0);
    check("no_second_ack", move_ack, 0);
    check("pos_stable_x", player_x, e.x);
    check("steps_stable", step_cnt, e.steps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x, y, s;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;

    //            req      oob addr tile  x   y  st lat we item
    vecs[0]  = mk(4'b0001, 0, 136,   0,  6, 10, 1, 4, 0,  0);
    vecs[1]  = mk(4'b1000, 0, 137,  20,  7, 10, 2, 5, 1, 20);
    vecs[2]  = mk(4'b0001, 0, 124,   5,  7, 10, 2, 4, 0, 20);
    vecs[3]  = mk(4'b0100, 0, 136,   0,  6, 10, 3, 4, 0, 20);
    vecs[4]  = mk(4'b0010, 0, 149,  31,  6, 11, 4, 5, 1, 31);
    vecs[5]  = mk(4'b0010, 0, 162,  16,  6, 12, 5, 5, 1, 16);
    vecs[6]  = mk(4'b0010, 1, 162,   0,  6, 12, 5, 2, 0, 16);
    vecs[7]  = mk(4'b1000, 0, 163,  32,  6, 12, 5, 4, 0, 16);
    vecs[8]  = mk(4'b0100, 0, 161,  15,  6, 12, 5, 4, 0, 16);
    vecs[9]  = mk(4'b1001, 0, 149,   0,  6, 11, 6, 4, 0, 16);
    vecs[10] = mk(4'b0110, 0, 162,   0,  6, 12, 7, 4, 0, 16);
    vecs[11] = mk(4'b1100, 0, 161,   0,  5, 12, 8, 4, 0, 16);

    rstn = 1'b0;
    move_req = 4'd0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check("rst_player_x", player_x, 6);
    check("rst_player_y", player_y, 11);
    check("rst_map_addr", map_addr, 0);
    check("rst_map_we", map_we, 0);
    check("rst_map_wdata", map_wdata, 0);
    check("rst_move_ack", move_ack, 0);
    check("rst_item_got", item_got, 0);
    check("rst_item_id", item_id, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_busy", busy, 0);

    for (int i = 0; i < 12; i++) run_move(vecs[i]);

    // Reset while the target tile read is outstanding.
    mem[148] = 16'd0;
    move_req = 4'b0001;
    tick();
    tick();
    check("read_addr", map_addr, 148);
    rstn = 1'b0;
    move_req = 4'd0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_x", player_x, 6);
    check("midrst_y", player_y, 11);
    check("midrst_we", map_we, 0);
    check("midrst_steps", step_cnt, 0);
    check("midrst_addr", map_addr, 0);
    rstn = 1'b1;
    tick();
    tick();
    check("midrst_no_ack", move_ack, 0);
    check("midrst_stays_idle", busy, 0);

    // Walk to every map edge and bump into it.
    x = 6; y = 11; s = 0;
    for (int i = 0; i < 6; i++) begin
      x--; s++;
      run_move(mk(4'b0100, 0, y * 13 + x, 0, x, y, s, 4, 0, 0));
    end
    run_move(mk(4'b0100, 1, y * 13 + x, 0, x, y, s, 2, 0, 0));
    for (int i = 0; i < 12; i++) begin
      x++; s++;
      run_move(mk(4'b1000, 0, y * 13 + x, 0, x, y, s, 4, 0, 0));
    end
    run_move(mk(4'b1000, 1, y * 13 + x, 0, x, y, s, 2, 0, 0));
    for (int i = 0; i < 11; i++) begin
      y--; s++;
      run_move(mk(4'b0001, 0, y * 13 + x, 0, x, y, s, 4, 0, 0));
    end
    run_move(mk(4'b0001, 1, y * 13 + x, 0, x, y, s, 2, 0, 0));

    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_step_ctrl.md
Name: player_step_ctrl

Overview:
Sequential controller that turns latched button requests into validated player moves on the tile map. It sits between the button request register and the map bRAM's port B, feeding player position to the map renderer. It replaces the single-cycle move/clear path with a proper handshake. The handshake accounts for bRAM read latency, map boundaries, and item pickup, where picking up an item writes floor back into the map.

Parameters:
MAP_WIDTH, 13, tiles per map row
MAP_HEIGHT, 13, tile rows
START_X, 6, player x after reset
START_Y, 11, player y after reset
RD_LAT, 1, map bRAM read latency in cycles (1..3)
TILE_FLOOR, 0, passable tile id; also written back after pickup
ITEM_LO, 16, lowest item tile id (inclusive)
ITEM_HI, 31, highest item tile id (inclusive)

Ports:
clk  in  1  system clock, 100 MHz
rstn  in  1  synchronous active-low reset
move_req  in  4  pending direction requests: [0] up, [1] down, [2] left, [3] right
move_ack  out  1  one-cycle pulse; upstream clears move_req on it
map_addr  out  19  map port-B address = y*MAP_WIDTH + x
map_rdata  in  16  map port-B read data (tile id)
map_we  out  1  map port-B write enable
map_wdata  out  16  map port-B write data
player_x  out  4  current player column
player_y  out  4  current player row
busy  out  1  high whenever state != IDLE
item_got  out  1  one-cycle pulse on pickup
item_id  out  16  tile id of last picked item; held until the next pickup
step_cnt  out  16  successful moves; saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rstn.
- Reset values:
  - player_x=START_X, player_y=START_Y
  - map_addr=0, map_we=0, map_wdata=0
  - move_ack=0, item_got=0, item_id=0, step_cnt=0, busy=0
  - state=IDLE
- States: IDLE, CHECK, READ, DECIDE, WRITE, ACK, GAP.
- IDLE:
  - On move_req != 0, latch one direction with fixed priority up > down > left > right.
  - Compute the target position, then go to CHECK.
- CHECK:
  - Out of bounds (up at y=0, down at y=MAP_HEIGHT-1, left at x=0, right at x=MAP_WIDTH-1): go to ACK. No read, position unchanged.
  - Otherwise drive map_addr = target address (zero-extended) and go to READ.
- READ:
  - Hold map_addr for RD_LAT cycles using a down-counter, then go to DECIDE.
- DECIDE:
  - map_rdata == TILE_FLOOR: update player_x/y to the target, increment step_cnt, go to ACK.
  - ITEM_LO <= map_rdata <= ITEM_HI: capture item_id = map_rdata, go to WRITE.
  - Any other id (blocked): go to ACK, position unchanged.
- WRITE:
  - For exactly 1 cycle: map_we=1, map_wdata=TILE_FLOOR, map_addr = target.
  - item_got=1 in this cycle.
  - Update position to the target and increment step_cnt at the end of the cycle.
  - Go to ACK.
- ACK:
  - move_ack=1 for exactly 1 cycle, then go to GAP.
- GAP:
  - 1 cycle; move_req is ignored so the upstream clear can propagate. Then go to IDLE.
- Latency from IDLE sample to move_ack:
  - Floor or blocked: 3+RD_LAT cycles.
  - Item: 4+RD_LAT cycles.
  - Out of bounds: 2 cycles.
- Width rules:
  - map_addr is computed as 19-bit unsigned y*MAP_WIDTH+x; no overflow is possible for legal parameters.
  - Coordinates are 4-bit, so MAP_WIDTH and MAP_HEIGHT must be <= 16.
- Request handling:
  - New requests arriving while busy are not lost; they remain in move_req.
  - Only the latched direction is serviced.
  - The ack clears all pending bits upstream, so extra simultaneous bits are dropped by design.
- Reset mid-operation:
  - Takes effect at the next edge regardless of state.
  - A write in progress is suppressed: map_we=0 on the reset cycle.
- Outputs are registered; no combinational path from map_rdata or move_req to any output.

Decomposition:
- Shared game_params package: MAP_WIDTH, MAP_HEIGHT, TILE_FLOOR, ITEM_LO, ITEM_HI, start coordinates, direction bit indices.
- State encoding is local to the module.
- One sub-module: step_target. It is combinational: it takes direction and position and returns target x/y, out_of_bounds, and the 19-bit address.

Test Plan:
1. Reset, then move_req=4'b0001 with tile 136 (6,10) = TILE_FLOOR, RD_LAT=1 -> map_addr=136; player_y=10 after DECIDE; move_ack single pulse 4 cycles after sample; step_cnt=1.
2. From (6,11), move_req=4'b1000 with tile 150 = 20 -> map_we=1 one cycle at addr 150 with wdata=0; item_got pulse; item_id=20; player_x=7; move_ack 5 cycles after sample.
3. Tile 136 = 5 (wall), move_req=4'b0001 -> position stays (6,11); map_we never asserted; step_cnt unchanged; move_ack pulses.
4. Position (0,11), move_req=4'b0100 -> map_addr unchanged; move_ack 2 cycles after sample; no position change.
5. move_req=4'b1001 -> up serviced (addr 136); right ignored; one ack only; move_req held high through GAP causes no second move.
6. rstn low during READ -> next cycle state IDLE, player=(6,11), busy=0, map_we=0, step_cnt=0.
